// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte buffer behind the UART receiver.
// Registered level/empty/full status and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_level,
  input  logic              i_clr_ovf,
  output logic              o_overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              pop_ok;
  logic              push_ok;

  // A full buffer still accepts a push when a pop frees a slot this cycle
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  assign o_pop_data = mem[rd_ptr];

  // Next occupancy, so flags can be registered together with the level
  always_comb begin
    level_nxt = o_level;
    unique case (1'b1)
      push_ok & ~pop_ok: level_nxt = o_level + 1'b1;
      pop_ok & ~push_ok: level_nxt = o_level - 1'b1;
      default:           level_nxt = o_level;
    endcase
  end

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

  // Pointers, level and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      o_level <= level_nxt;
      o_empty <= (level_nxt == '0);
      o_full  <= (level_nxt == FULL_LVL);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (i_push & ~push_ok) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random stimulus against a queue model.
// Driver updates the model; a negedge monitor checks status and data.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       clr_ovf;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  byte unsigned exp_q[$];
  int  cur_level = 0;
  int  nxt_level = 0;
  bit  cur_ovf = 0;
  bit  nxt_ovf = 0;
  bit  chk_en = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_push     (push),
    .i_push_data(push_data),
    .i_pop      (pop),
    .o_pop_data (pop_data),
    .o_empty    (empty),
    .o_full     (full),
    .o_level    (level),
    .i_clr_ovf  (clr_ovf),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model steps by the buffer's rules
  task automatic cyc(input bit p, input byte unsigned d,
                     input bit q, input bit c, input bit r);
    bit pop_ok;
    bit push_ok;
    @(posedge clk);
    #1;
    cur_level = nxt_level;
    cur_ovf   = nxt_ovf;
    reset     = r;
    push      = p;
    push_data = d;
    pop       = q;
    clr_ovf   = c;
    if (r) begin
      nxt_level = 0;
      nxt_ovf   = 0;
      exp_q.delete();
    end else begin
      pop_ok  = q && (cur_level != 0);
      push_ok = p && ((cur_level != 16) || pop_ok);
      if (push_ok) exp_q.push_back(d);
      nxt_level = cur_level + int'(push_ok) - int'(pop_ok);
      if (p && !push_ok) nxt_ovf = 1;
      else if (c)        nxt_ovf = 0;
      else               nxt_ovf = cur_ovf;
    end
  endtask

  // Monitor: status each cycle, head byte while non-empty
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("level", int'(level), cur_level);
      check("empty", int'(empty), int'(cur_level == 0));
      check("full", int'(full), int'(cur_level == 16));
      check("overflow", int'(overflow), int'(cur_ovf));
      if (cur_level != 0) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          check("pop_data", int'(pop_data), int'(exp_q[0]));
          if (pop) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; push = 1'b0; push_data = '0;
    pop = 1'b0; clr_ovf = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk_en = 1;

    // Three bytes in, three out
    cyc(1, 8'h41, 0, 0, 0);
    cyc(1, 8'h42, 0, 0, 0);
    cyc(1, 8'h43, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) cyc(1, byte'(i), 0, 0, 0);
    cyc(1, 8'hFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) cyc(1, byte'(i), 0, 0, 0);
    cyc(1, 8'hAA, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);

    // Empty with push and pop; pop on empty
    cyc(1, 8'h5A, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Wrap-around with interleaved pairs
    for (int i = 0; i < 40; i++) begin
      cyc(1, byte'(i + 8'h80), 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(1, 8'h11, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, byte'(i), 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Overflow set while clear pulses, then clear alone
    for (int i = 0; i < 16; i++) cyc(1, byte'(8'h30 + i), 0, 0, 0);
    cyc(1, 8'hEE, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Reset mid-stream with level 5 during a push
    cyc(1, 8'hEE, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, byte'(8'h60 + i), 0, 0, 0);
    cyc(1, 8'h77, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 8'h12, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 55,
          byte'($urandom_range(0, 255)),
          $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
